// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl
//   Sits between two byte producers and a UART core. Two independent FSMs
//   share the block but never interact:
//     - TX: round-robin arbitration between two requesters, loads the
//       winning byte into the transmitter with a one-cycle write strobe,
//       then tracks the busy handshake. A busy that never rises is
//       abandoned after BUSY_WAIT cycles.
//     - RX: when the receiver reports data, captures the byte and its
//       parity status, issues a one-cycle read strobe with a coincident
//       rx_valid, then waits for data_ready to drop before rearming.
//   Ports
//     clk, rst_n                 clock, async active-low reset
//     reqN_valid/data/ready      requester handshakes (ready is combinational)
//     pi_tx_data, write_flag     byte and load strobe to the transmitter
//     busy_flag                  transmitter busy
//     data_ready, po_rx_data,
//     parity_error, read_flag    receiver status/data and read strobe
//     rx_data, rx_valid,
//     rx_parity_err              captured receive byte and status
//     last_grant                 id of the most recently granted requester
module uart_host_ctrl #(
   parameter int BUSY_WAIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic [7:0] pi_tx_data,
   output logic       write_flag,
   input  logic       busy_flag,
   input  logic       data_ready,
   input  logic [7:0] po_rx_data,
   input  logic       parity_error,
   output logic       read_flag,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       last_grant
);

   typedef enum logic [1:0] {T_IDLE, T_LOAD, T_RISE, T_FALL} tx_state_e;
   typedef enum logic [1:0] {R_IDLE, R_READ, R_WAIT} rx_state_e;

   // Counter only needs to reach BUSY_WAIT-1.
   localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_WAIT - 1);

   tx_state_e  tx_state_q, tx_state_d;
   rx_state_e  rx_state_q, rx_state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] pi_tx_data_q, pi_tx_data_d;
   logic       write_flag_q, write_flag_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_parity_err_q, rx_parity_err_d;

   logic gnt_any;
   logic gnt_id;

   // Arbitration: a lone requester wins; with both valid the one that
   // did not win last time goes. Grants only when idle and not busy.
   always_comb begin
      gnt_any    = (tx_state_q == T_IDLE) && !busy_flag && (req0_valid || req1_valid);
      gnt_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      req0_ready = gnt_any && !gnt_id;
      req1_ready = gnt_any &&  gnt_id;
   end

   // TX next-state
   always_comb begin
      tx_state_d   = tx_state_q;
      cnt_d        = cnt_q;
      pi_tx_data_d = pi_tx_data_q;
      write_flag_d = 1'b0;
      last_grant_d = last_grant_q;
      case (tx_state_q)
         T_IDLE: begin
            if (gnt_any) begin
               pi_tx_data_d = gnt_id ? req1_data : req0_data;
               last_grant_d = gnt_id;
               write_flag_d = 1'b1;     // high exactly while in T_LOAD
               tx_state_d   = T_LOAD;
            end
         end
         T_LOAD: begin
            cnt_d      = '0;
            tx_state_d = T_RISE;
         end
         T_RISE: begin
            if (busy_flag) begin
               cnt_d      = '0;
               tx_state_d = T_FALL;
            end else if (cnt_q == CNT_LAST) begin
               // transmitter never started; give up so the bus does not hang
               cnt_d      = '0;
               tx_state_d = T_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         T_FALL: begin
            if (!busy_flag) tx_state_d = T_IDLE;
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   // RX next-state. read_flag and rx_valid are the same flop: both are
   // high for the single cycle spent in R_READ.
   always_comb begin
      rx_state_d      = rx_state_q;
      rx_data_d       = rx_data_q;
      rx_parity_err_d = rx_parity_err_q;
      rx_valid_d      = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (data_ready) begin
               rx_data_d       = po_rx_data;
               rx_parity_err_d = parity_error;
               rx_valid_d      = 1'b1;
               rx_state_d      = R_READ;
            end
         end
         R_READ: rx_state_d = R_WAIT;
         R_WAIT: begin
            // wait for the receiver to drop data_ready so a byte is read once
            if (!data_ready) rx_state_d = R_IDLE;
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q      <= T_IDLE;
         rx_state_q      <= R_IDLE;
         cnt_q           <= '0;
         pi_tx_data_q    <= 8'h00;
         write_flag_q    <= 1'b0;
         last_grant_q    <= 1'b1;   // requester 0 wins first after reset
         rx_data_q       <= 8'h00;
         rx_valid_q      <= 1'b0;
         rx_parity_err_q <= 1'b0;
      end else begin
         tx_state_q      <= tx_state_d;
         rx_state_q      <= rx_state_d;
         cnt_q           <= cnt_d;
         pi_tx_data_q    <= pi_tx_data_d;
         write_flag_q    <= write_flag_d;
         last_grant_q    <= last_grant_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         rx_parity_err_q <= rx_parity_err_d;
      end
   end

   assign pi_tx_data    = pi_tx_data_q;
   assign write_flag    = write_flag_q;
   assign last_grant    = last_grant_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign read_flag     = rx_valid_q;
   assign rx_parity_err = rx_parity_err_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed bench for uart_host_ctrl. Expected TX bytes and RX captures are
// queued when stimulus is driven; a negedge monitor pops and compares them
// whenever write_flag / rx_valid fire. A small responder raises busy_flag
// after each write strobe when auto_busy is set.
module tb_uart_host_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic [7:0] pi_tx_data;
   logic       write_flag;
   logic       busy_flag = 1'b0;
   logic       data_ready;
   logic [7:0] po_rx_data;
   logic       parity_error;
   logic       read_flag;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_parity_err;
   logic       last_grant;

   int checks   = 0;
   int failures = 0;

   logic [7:0] tx_q[$];
   logic [8:0] rx_q[$];   // {parity, data}

   bit auto_busy = 1'b1;
   int busy_len  = 3;

   uart_host_ctrl #(.BUSY_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .pi_tx_data(pi_tx_data), .write_flag(write_flag), .busy_flag(busy_flag),
      .data_ready(data_ready), .po_rx_data(po_rx_data), .parity_error(parity_error),
      .read_flag(read_flag), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_parity_err(rx_parity_err), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wf(input string tag, input int max);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!write_flag && n < max);
      chk(tag, write_flag, 1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (write_flag) begin
            if (tx_q.size() == 0) chk("tx_unexpected_write", write_flag, 0);
            else chk("tx_byte", pi_tx_data, tx_q.pop_front());
         end
         if (rx_valid || read_flag) begin
            chk("rx_strobes", {read_flag, rx_valid}, 2'b11);
            if (rx_q.size() == 0) chk("rx_unexpected_valid", rx_valid, 0);
            else chk("rx_capture", {rx_parity_err, rx_data}, rx_q.pop_front());
         end
      end
   end

   // transmitter model: busy rises the cycle after the load strobe
   always begin
      @(negedge clk);
      if (rst_n === 1'b1 && write_flag && auto_busy) begin
         @(posedge clk);
         #1 busy_flag = 1'b1;
         repeat (busy_len) @(posedge clk);
         #1 busy_flag = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
      data_ready = 0; po_rx_data = 0; parity_error = 0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_write_flag", write_flag, 0);
      chk("rst_read_flag", read_flag, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_parity", rx_parity_err, 0);
      chk("rst_pi_tx_data", pi_tx_data, 8'h00);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_last_grant", last_grant, 1);
      cyc();
      rst_n = 1'b1;

      // single request
      cyc();
      req0_valid = 1; req0_data = 8'hA5; tx_q.push_back(8'hA5);
      @(negedge clk);
      chk("t1_ready0", req0_ready, 1);
      chk("t1_ready1", req1_ready, 0);
      chk("t1_wf_before", write_flag, 0);
      cyc();
      @(negedge clk);
      chk("t1_wf", write_flag, 1);
      chk("t1_ready0_load", req0_ready, 0);
      chk("t1_last_grant", last_grant, 0);
      cyc();
      req0_valid = 0;
      repeat (8) cyc();

      // simultaneous req1 grant and RX data
      req1_valid = 1; req1_data = 8'h3C; tx_q.push_back(8'h3C);
      data_ready = 1; po_rx_data = 8'h5A; parity_error = 0; rx_q.push_back({1'b0, 8'h5A});
      @(negedge clk);
      chk("t4_ready1", req1_ready, 1);
      chk("t4_ready0", req0_ready, 0);
      cyc();
      req1_valid = 0;
      @(negedge clk);
      chk("t4_wf", write_flag, 1);
      chk("t4_rf", read_flag, 1);
      chk("t4_last_grant", last_grant, 1);
      cyc();
      data_ready = 0;
      repeat (8) cyc();

      // contention with round-robin
      busy_len = 10;
      req0_valid = 1; req0_data = 8'h11;
      req1_valid = 1; req1_data = 8'h22;
      tx_q.push_back(8'h11); tx_q.push_back(8'h22);
      tx_q.push_back(8'h11); tx_q.push_back(8'h22);
      for (int k = 0; k < 4; k++) begin
         wait_wf("t2_wf", 30);
         chk("t2_last_grant", last_grant, k % 2);
      end
      cyc();
      req0_valid = 0; req1_valid = 0;
      repeat (15) cyc();

      // lost start: busy never rises
      auto_busy = 1'b0;
      req0_valid = 1; req0_data = 8'h77; tx_q.push_back(8'h77);
      wait_wf("t3_wf", 5);
      cyc();
      req0_data = 8'h88; tx_q.push_back(8'h88);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_ready_rise", req0_ready, 0);
         cyc();
      end
      @(negedge clk);
      chk("t3_ready_back", req0_ready, 1);
      cyc();
      req0_valid = 0;
      @(negedge clk);
      chk("t3_wf2", write_flag, 1);
      repeat (8) cyc();
      auto_busy = 1'b1;
      busy_len  = 3;

      // RX held 20 cycles: exactly one capture
      data_ready = 1; po_rx_data = 8'hF9; parity_error = 1; rx_q.push_back({1'b1, 8'hF9});
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (rx_valid) n++;
      end
      cyc();
      data_ready = 0; po_rx_data = 8'h00; parity_error = 0;
      repeat (3) cyc();
      chk("t5_pulses", n, 1);
      chk("t5_rx_data_hold", rx_data, 8'hF9);
      chk("t5_parity_hold", rx_parity_err, 1);

      // reset during T_FALL with requests pending
      busy_len = 50;
      req0_valid = 1; req0_data = 8'h44; tx_q.push_back(8'h44);
      wait_wf("t6_wf", 5);
      cyc();
      req1_valid = 1; req1_data = 8'h55; req0_data = 8'h66;
      repeat (5) cyc();
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_last_grant", last_grant, 1);
      chk("t6_rst_pi_tx_data", pi_tx_data, 8'h00);
      for (int i = 0; i < 3; i++) begin
         chk("t6_rst_wf", write_flag, 0);
         @(negedge clk);
      end
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_busy_ready0", req0_ready, 0);
      chk("t6_busy_ready1", req1_ready, 0);
      busy_len = 2;
      tx_q.push_back(8'h66);
      wait_wf("t6_wf_after", 80);
      chk("t6_last_grant", last_grant, 0);
      cyc();
      req0_valid = 0; req1_valid = 0;
      repeat (10) cyc();

      chk("tx_queue_empty", tx_q.size(), 0);
      chk("rx_queue_empty", rx_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_host_ctrl.md
UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter BUSY_WAIT, default 4, meaning the maximum cycles to wait for busy_flag to rise after a write_flag pulse.
REQ-002 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid  in  1  each  TX byte offered by requester 0/1.
REQ-005 SHALL have ports req0_data/req1_data  in  8  each  byte offered.
REQ-006 SHALL have ports req0_ready/req1_ready  out  1  each  byte accepted this cycle.
REQ-007 SHALL have port pi_tx_data  out  8  byte to the transmitter.
REQ-008 SHALL have port write_flag  out  1  one-cycle transmitter load strobe.
REQ-009 SHALL have port busy_flag  in  1  transmitter busy.
REQ-010 SHALL have ports data_ready  in  1, po_rx_data  in  8, parity_error  in  1  receiver status/data.
REQ-011 SHALL have port read_flag  out  1  one-cycle receiver read strobe.
REQ-012 SHALL have ports rx_data  out  8, rx_valid  out  1, rx_parity_err  out  1  captured receive byte, one-cycle valid, parity status.
REQ-013 SHALL have port last_grant  out  1  id of most recently granted requester.

Function
REQ-014 TX FSM SHALL have states T_IDLE, T_LOAD, T_RISE, T_FALL.
REQ-015 In T_IDLE with busy_flag=0 and any reqN_valid=1, reqN_ready SHALL assert combinationally for the granted requester only; other ready=0.
REQ-016 Arbitration SHALL be round-robin: single valid wins; both valid -> requester != last_grant wins.
REQ-017 On the grant edge: pi_tx_data <= granted data, last_grant <= granted id, state -> T_LOAD.
REQ-018 T_LOAD SHALL last exactly 1 cycle with write_flag=1 (registered), then -> T_RISE; write_flag=0 in all other states.
REQ-019 T_RISE: busy_flag=1 -> T_FALL; else after BUSY_WAIT cycles in T_RISE -> T_IDLE (lost-start recovery).
REQ-020 T_FALL: busy_flag=0 -> T_IDLE; no timeout.
REQ-021 Grant-to-write_flag latency SHALL be 1 cycle; minimum byte-to-byte spacing 3 cycles plus transmitter busy time.
REQ-022 pi_tx_data SHALL hold its value until the next grant.
REQ-023 reqN_ready SHALL be 0 in every state other than T_IDLE and whenever busy_flag=1.
REQ-024 RX FSM SHALL have states R_IDLE, R_READ, R_WAIT.
REQ-025 R_IDLE with data_ready=1 -> R_READ; on that edge rx_data <= po_rx_data, rx_parity_err <= parity_error.
REQ-026 R_READ SHALL last 1 cycle with read_flag=1 and rx_valid=1 (both registered, coincident), then -> R_WAIT.
REQ-027 R_WAIT SHALL return to R_IDLE only when data_ready=0, so one byte is never read twice.
REQ-028 RX and TX FSMs SHALL run independently; simultaneous data_ready and reqN_valid SHALL both be serviced in the same cycle.
REQ-029 rx_data/rx_parity_err SHALL hold until the next capture.

Reset
REQ-030 rst_n=0 SHALL asynchronously force T_IDLE, R_IDLE, write_flag=0, read_flag=0, rx_valid=0, rx_parity_err=0, pi_tx_data=8'h00, rx_data=8'h00, last_grant=1 (requester 0 wins first), BUSY_WAIT counter=0.
REQ-031 Reset asserted mid-transfer SHALL abort both FSMs with no further strobe; after release the first grant SHALL again favour requester 0.

Verification
REQ-032 Single request: req0_valid=1, data 8'hA5, busy_flag=0 -> req0_ready 1 cycle, next cycle write_flag=1, pi_tx_data=8'hA5.
REQ-033 Contention: both valid (8'h11, 8'h22) held, busy pulses 10 cycles after each write_flag -> pi_tx_data sequence 11,22,11,22; last_grant toggles.
REQ-034 Lost start: busy_flag held 0 after write_flag -> FSM back in T_IDLE after BUSY_WAIT=4 cycles; next request accepted.
REQ-035 RX: data_ready=1 with po_rx_data=8'hF9, parity_error=1, held 20 cycles -> exactly one read_flag/rx_valid pulse, rx_data=8'hF9, rx_parity_err=1.
REQ-036 Simultaneous: data_ready rises same cycle as req1 grant -> read_flag and write_flag both asserted the following cycle.
REQ-037 Reset during T_FALL with req0 pending -> write_flag stays 0 during reset; after release req0 granted first.
